// File: rtl/req_encoder_8to3_pkg.sv
// Shared constants and types for the 8-to-3 request encoder.
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN.
package enc_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = $clog2(WIDTH);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/req_encoder_8to3_if.sv
// Valid/ready output bundle carrying the encoded index.
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN.
interface req_encoder_8to3_if;
    import enc_pkg::*;

    idx_t dout;
    logic dout_vld;
    logic dout_rdy;

    modport master (
        output dout,
        output dout_vld,
        input  dout_rdy
    );

    modport slave (
        input  dout,
        input  dout_vld,
        output dout_rdy
    );

endinterface

// File: rtl/req_encoder_8to3_prio_find.sv
// Find-first-set over WIDTH bits, searching upward from start.
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN.
module prio_find
    import enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    input  idx_t             start,
    output idx_t             idx
);

    idx_t pos;
    logic found;

    // Walk the vector from start with wrap-around; first hit wins.
    always_comb begin
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = start + idx_t'(i);
            if (!found && vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder_8to3.sv
// Serialises request pulses into binary indices on a valid/ready port.
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN (rotating priority).
module req_encoder_8to3
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    req_encoder_8to3_if.master out_if,
    output logic             busy,
    output logic             coalesce
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    idx_t             dout_q, dout_d;
    logic             coalesce_q, coalesce_d;

    logic             accept;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] sel_vec;
    idx_t             start;
    idx_t             found_idx;

    assign accept = (state_q == PRESENT) && out_if.dout_rdy;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    idx_t last_q, last_d;

    // Remember the last accepted index; search resumes just past it.
    always_comb begin
        last_d = accept ? dout_q : last_q;
        start  = (accept ? dout_q : last_q) + idx_t'(1);
    end

    // Last-accepted register, reset so the first search begins at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= idx_t'(WIDTH - 1);
        else        last_q <= last_d;
    end
`else
    assign start = '0;
`endif

    // Pending update: a new pulse on the bit being cleared keeps it set.
    always_comb begin
        clr = '0;
        if (accept) clr[dout_q] = 1'b1;
        rem        = pend_q & ~clr;
        pend_d     = rem | din;
        coalesce_d = |(din & pend_q & ~clr);
        sel_vec    = (state_q == IDLE) ? pend_q : rem;
    end

    prio_find u_find (
        .vec   (sel_vec),
        .start (start),
        .idx   (found_idx)
    );

    // Next-state and presented index; dout holds unless reloaded.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    dout_d  = found_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    if (|rem) dout_d = found_idx;
                    else      state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending set, presented index and coalesce flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            dout_q     <= '0;
            coalesce_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            dout_q     <= dout_d;
            coalesce_q <= coalesce_d;
        end
    end

    assign out_if.dout     = dout_q;
    assign out_if.dout_vld = (state_q == PRESENT);
    assign busy            = (|pend_q) | (state_q == PRESENT);
    assign coalesce        = coalesce_q;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Directed bench for req_encoder_8to3 (default fixed-priority build).
// Optional build macro: REQ_ENCODER_ROUND_ROBIN_EN.
module tb_req_encoder_8to3;
    import enc_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             coalesce;
    int               total;
    int               passed;
    int               failed;

    req_encoder_8to3_if u_if ();

    req_encoder_8to3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .out_if   (u_if),
        .busy     (busy),
        .coalesce (coalesce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld,
                           input logic [2:0] idx, input logic bsy);
        chk({tag, "_vld"}, {7'd0, u_if.dout_vld}, {7'd0, vld});
        chk({tag, "_dout"}, {5'd0, u_if.dout}, {5'd0, idx});
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, bsy});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n  = 1'b0;
        din    = '0;
        u_if.dout_rdy = 1'b0;
        tick();
        tick();
        chk_out("rst", 1'b0, 3'd0, 1'b0);
        chk("rst_coal", {7'd0, coalesce}, 8'h00);
        rst_n = 1'b1;
        tick();

        // single request, 2-cycle latency, one-cycle presentation
        u_if.dout_rdy = 1'b1;
        din = 8'b0000_0100;
        tick();
        chk_out("one_t0", 1'b0, 3'd0, 1'b1);
        din = '0;
        tick();
        chk_out("one_t1", 1'b1, 3'd2, 1'b1);
        tick();
        chk_out("one_t2", 1'b0, 3'd2, 1'b0);
        chk("one_coal", {7'd0, coalesce}, 8'h00);

        // multi-hot burst drains lowest-first back-to-back
        din = 8'b1000_0011;
        tick();
        din = '0;
        tick();
        chk_out("multi_0", 1'b1, 3'd0, 1'b1);
        tick();
        chk_out("multi_1", 1'b1, 3'd1, 1'b1);
        tick();
        chk_out("multi_7", 1'b1, 3'd7, 1'b1);
        tick();
        chk_out("multi_end", 1'b0, 3'd7, 1'b0);

        // backpressure holds dout stable
        u_if.dout_rdy = 1'b0;
        din = 8'b0001_0000;
        tick();
        din = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("hold", 1'b1, 3'd4, 1'b1);
        end
        u_if.dout_rdy = 1'b1;
        tick();
        chk_out("hold_acc", 1'b0, 3'd4, 1'b0);
        tick();
        chk_out("hold_once", 1'b0, 3'd4, 1'b0);

        // pulse on a pending bit merges and flags coalesce once
        u_if.dout_rdy = 1'b0;
        din = 8'b0000_1000;
        tick();
        din = '0;
        tick();
        chk_out("coal_pres", 1'b1, 3'd3, 1'b1);
        chk("coal_pre", {7'd0, coalesce}, 8'h00);
        din = 8'b0000_1000;
        tick();
        chk("coal_hi", {7'd0, coalesce}, 8'h01);
        din = '0;
        tick();
        chk("coal_lo", {7'd0, coalesce}, 8'h00);
        u_if.dout_rdy = 1'b1;
        tick();
        chk_out("coal_acc", 1'b0, 3'd3, 1'b0);
        tick();
        chk_out("coal_once", 1'b0, 3'd3, 1'b0);

        // re-pulse on the bit being accepted wins and re-presents
        u_if.dout_rdy = 1'b0;
        din = 8'b0010_0000;
        tick();
        din = '0;
        tick();
        chk_out("rep_pres", 1'b1, 3'd5, 1'b1);
        u_if.dout_rdy = 1'b1;
        din = 8'b0010_0000;
        tick();
        chk_out("rep_acc", 1'b0, 3'd5, 1'b1);
        chk("rep_coal", {7'd0, coalesce}, 8'h00);
        din = '0;
        tick();
        chk_out("rep_again", 1'b1, 3'd5, 1'b1);
        tick();
        chk_out("rep_end", 1'b0, 3'd5, 1'b0);

        // bit 0 re-pulsed while accepting 0: 7 is already next
        din = 8'h81;
        tick();
        din = '0;
        tick();
        chk_out("ord_0", 1'b1, 3'd0, 1'b1);
        din = 8'h01;
        tick();
        chk_out("ord_7", 1'b1, 3'd7, 1'b1);
        din = '0;
        tick();
        chk_out("ord_0b", 1'b1, 3'd0, 1'b1);
        tick();
        chk_out("ord_end", 1'b0, 3'd0, 1'b0);

        // async reset mid-transfer discards everything
        u_if.dout_rdy = 1'b0;
        din = 8'hFF;
        tick();
        tick();
        chk_out("rr_pre", 1'b1, 3'd0, 1'b1);
        chk("rr_coal", {7'd0, coalesce}, 8'h01);
        din = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 3'd0, 1'b0);
        chk("arst_coal", {7'd0, coalesce}, 8'h00);
        #2;
        rst_n = 1'b1;
        u_if.dout_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("post_rst", 1'b0, 3'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
